frame_receiver: RTL and testbench
=================================

Name: frame_receiver

Overview:
- Parametrised serial-to-parallel request receiver: reassembles {address, data} frames arriving over a narrow beat bus into full-width memory requests.
- Frame length is validated: short frames are discarded and excess beats are dropped, each flagged by an error pulse.
- Completed requests are queued in a small FIFO and handed to the cache/memory side over a valid/ready handshake.
- Sits between the bus sender and the cache controller; adds buffering, back-pressure and error reporting.

Parameters:
- BUS_W, 8, beat width in bits.
- ADDR_W, 16, request address width.
- DATA_W, 32, request data width.
- FIFO_DEPTH, 4, request queue entries; power of two, >= 2.
- BEATS, derived as ceil((ADDR_W+DATA_W)/BUS_W), beats per legal frame; not overridable.

Ports:
- clk  in  1  clock; all state updates on the falling edge.
- reset  in  1  synchronous, active-high reset.
- send  in  1  frame-active strobe; one beat per cycle while high.
- write_in  in  1  op type, sampled in the frame-end cycle; 1=write, 0=read.
- bus  in  BUS_W  beat data.
- req_valid  out  1  FIFO head valid.
- req_ready  in  1  consumer accepts the head this cycle.
- req_write  out  1  head op: 1=write, 0=read.
- req_addr  out  ADDR_W  head address.
- req_data  out  DATA_W  head data.
- fifo_count  out  clog2(FIFO_DEPTH)+1  number of queued requests.
- short_err  out  1  one-cycle pulse: frame ended with fewer than BEATS beats.
- long_err  out  1  one-cycle pulse: a beat arrived after BEATS beats had been captured.
- ovf_err  out  1  one-cycle pulse: complete frame dropped because the FIFO was full.

Behaviour:
- Reset: state=IDLE; beat counter, assembly register and FIFO pointers cleared; req_valid=0, req_write=0, req_addr=0, req_data=0, fifo_count=0; all error pulses 0. Reset mid-frame discards the partial frame and performs no push. Reset overrides a simultaneous push or pop.
- FSM has two states, IDLE and RECV.
  - IDLE, send=1: capture beat 0, go to RECV, beat_cnt=1.
  - IDLE, send=0: no action.
  - RECV, send=1, beat_cnt<BEATS: write bus into assembly bits [beat_cnt*BUS_W +: BUS_W], then beat_cnt+1.
  - RECV, send=1, beat_cnt==BEATS: drop the beat and pulse long_err. The pulse repeats for every excess beat; the counter saturates.
  - RECV, send=0 (frame end): sample write_in and go to IDLE.
    - beat_cnt==BEATS: push {write_in, addr, data}.
    - beat_cnt<BEATS: pulse short_err; no push.
- Field mapping: beat 0 is least significant. data = assembly[DATA_W-1:0]; addr = assembly[DATA_W +: ADDR_W]. Bits of the final beat above ADDR_W+DATA_W are ignored.
- Back-to-back frames need at least one send=0 cycle between them. That cycle is the frame end.
- Push latency: the request is visible on req_* with req_valid=1 immediately after the frame-end edge, if the FIFO was empty.
- FIFO behaviour:
  - req_valid = (count != 0).
  - Pop occurs when req_valid && req_ready at an edge.
  - req_* show the head entry combinationally and hold stable while req_valid && !req_ready.
- Full FIFO:
  - Push with no simultaneous pop: frame dropped, ovf_err pulses, count unchanged.
  - Push with a simultaneous pop: both happen, count unchanged, no error.
- Empty FIFO with a simultaneous push and req_ready: no pop that edge; the new entry appears afterwards.
- Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0..FIFO_DEPTH.
- Errors are independent one-cycle pulses.

Decomposition:
- Shared defines header: BUS_W, ADDR_W and DATA_W defaults (existing bandwidth, address and word-size constants), plus the request packing macro {write, addr, data}.
- Sub-module frame_rx_fifo: synchronous FIFO with count; width 1+ADDR_W+DATA_W; FIFO_DEPTH entries; push, pop, full, empty.
- FSM, beat counter and assembly register live in the top module.

Test Plan (defaults, BEATS=6):
- Write frame: beats EF,BE,AD,DE,34,12, then send=0 with write_in=1 -> req_valid=1, req_write=1, req_addr=0x1234, req_data=0xDEADBEEF the cycle after frame end.
- Read frame: beats 00,00,00,00,CD,AB, then end with write_in=0 -> req_write=0, req_addr=0xABCD, req_data=0.
- Short frame of 4 beats -> short_err pulses once, fifo_count stays 0. A following legal frame is accepted normally.
- Long frame of 8 beats -> long_err pulses on beats 7 and 8; the request carries the first 6 beats only.
- With req_ready=0, send 5 legal frames -> fifo_count=4 and ovf_err on the 5th. Then req_ready=1 -> the 4 requests drain in order and fifo_count reaches 0.
- Reset asserted after 3 beats -> no push, no error pulses; a fresh 6-beat frame afterwards is received correctly.

Source files
------------

// File: rtl/frame_receiver_pkg.sv
// Shared constants, receiver state type and request packing macro for frame_receiver.
`ifndef FRAME_RX_PACK_REQ
`define FRAME_RX_PACK_REQ(wr, addr, data) {wr, addr, data}
`endif

package frame_receiver_pkg;

  localparam int DEF_BUS_W  = 8;
  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 32;

  typedef enum logic {
    IDLE = 1'b0,
    RECV = 1'b1
  } rx_state_t;

endpackage

// File: rtl/frame_rx_fifo.sv
// Synchronous request queue with occupancy count; head is shown combinationally.
module frame_rx_fifo #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full queue still accepts a push when the head leaves on the same edge.
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(negedge clk) begin
    if (!reset && do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/frame_receiver.sv
// Reassembles {address, data} frames from a narrow beat bus and queues them as requests.
module frame_receiver
  import frame_receiver_pkg::*;
#(
  parameter int BUS_W      = DEF_BUS_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          send,
  input  logic                          write_in,
  input  logic [BUS_W-1:0]              bus,
  output logic                          req_valid,
  input  logic                          req_ready,
  output logic                          req_write,
  output logic [ADDR_W-1:0]             req_addr,
  output logic [DATA_W-1:0]             req_data,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          short_err,
  output logic                          long_err,
  output logic                          ovf_err
);

  localparam int BEATS = (ADDR_W + DATA_W + BUS_W - 1) / BUS_W;
  localparam int ASM_W = BEATS * BUS_W;
  localparam int CNT_W = $clog2(BEATS + 1);
  localparam int REQ_W = 1 + ADDR_W + DATA_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS);

  rx_state_t        state;
  rx_state_t        next_state;
  logic [CNT_W-1:0] beat_cnt;
  logic [ASM_W-1:0] asm_reg;
  logic             capture;
  logic             long_hit;
  logic             short_hit;
  logic             frame_done;
  logic             pop;
  logic             full;
  logic             empty;
  logic [REQ_W-1:0] push_data;
  logic [REQ_W-1:0] head;

  always_ff @(negedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // The send=0 cycle that closes a frame decides between push and short error.
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    long_hit   = 1'b0;
    short_hit  = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (send) begin
          next_state = RECV;
          capture    = 1'b1;
        end
      end
      RECV: begin
        if (send) begin
          if (beat_cnt == LAST_CNT) long_hit = 1'b1;
          else                      capture  = 1'b1;
        end else begin
          next_state = IDLE;
          if (beat_cnt == LAST_CNT) frame_done = 1'b1;
          else                      short_hit  = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Beat counter is zero in IDLE, so beat 0 lands in the low slice like the rest.
  always_ff @(negedge clk) begin
    if (reset) begin
      beat_cnt  <= '0;
      asm_reg   <= '0;
      short_err <= 1'b0;
      long_err  <= 1'b0;
      ovf_err   <= 1'b0;
    end else begin
      short_err <= short_hit;
      long_err  <= long_hit;
      ovf_err   <= frame_done && full && !pop;
      if (capture) begin
        asm_reg[int'(beat_cnt)*BUS_W +: BUS_W] <= bus;
        beat_cnt <= beat_cnt + 1'b1;
      end else if (next_state == IDLE) begin
        beat_cnt <= '0;
      end
    end
  end

  assign push_data = `FRAME_RX_PACK_REQ(write_in, asm_reg[DATA_W +: ADDR_W], asm_reg[DATA_W-1:0]);
  assign pop       = req_valid && req_ready;
  assign req_valid = !empty;
  assign {req_write, req_addr, req_data} = head;

  frame_rx_fifo #(
    .WIDTH (REQ_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (frame_done),
    .pop   (pop),
    .wdata (push_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

endmodule

// File: tb/tb_frame_receiver.sv
// Directed self-checking bench for frame_receiver with hand-computed expected requests.
module tb_frame_receiver;

  logic        clk;
  logic        reset;
  logic        send;
  logic        write_in;
  logic [7:0]  bus;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [31:0] req_data;
  logic [2:0]  fifo_count;
  logic        short_err;
  logic        long_err;
  logic        ovf_err;

  int checkCount;
  int errorCount;

  frame_receiver dut (
    .clk        (clk),
    .reset      (reset),
    .send       (send),
    .write_in   (write_in),
    .bus        (bus),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .fifo_count (fifo_count),
    .short_err  (short_err),
    .long_err   (long_err),
    .ovf_err    (ovf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Advance past the active (falling) edge and settle before inputs change or outputs are read.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic s, input logic [7:0] b);
    send = s;
    bus  = b;
    step();
  endtask

  task automatic checkHead(input string tag, input logic wr, input logic [15:0] addr, input logic [31:0] data);
    checkOutput({tag, " valid"}, 64'(req_valid), 64'(1'b1));
    checkOutput({tag, " write"}, 64'(req_write), 64'(wr));
    checkOutput({tag, " addr"},  64'(req_addr),  64'(addr));
    checkOutput({tag, " data"},  64'(req_data),  64'(data));
  endtask

  task automatic sendFrame(input string tag, input logic [63:0] beats, input int n,
                           input logic wr, input logic ready_end, input logic exp_ovf);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, beats[i*8 +: 8]);
      checkOutput({tag, " long_err"}, 64'(long_err), 64'(i >= 6));
    end
    write_in  = wr;
    req_ready = ready_end;
    applyStimulus(1'b0, 8'h00);
    checkOutput({tag, " end short_err"}, 64'(short_err), 64'(n < 6));
    checkOutput({tag, " end long_err"},  64'(long_err),  64'(1'b0));
    checkOutput({tag, " end ovf_err"},   64'(ovf_err),   64'(exp_ovf));
  endtask

  task automatic drainOne(input string tag, input logic [2:0] exp_count);
    req_ready = 1'b1;
    step();
    req_ready = 1'b0;
    checkOutput({tag, " count"}, 64'(fifo_count), 64'(exp_count));
  endtask

  initial begin
    checkCount = 0;
    errorCount = 0;
    reset      = 1'b1;
    send       = 1'b0;
    write_in   = 1'b0;
    bus        = 8'h00;
    req_ready  = 1'b0;
    step();
    step();
    checkOutput("reset valid",  64'(req_valid),  64'(0));
    checkOutput("reset write",  64'(req_write),  64'(0));
    checkOutput("reset addr",   64'(req_addr),   64'(0));
    checkOutput("reset data",   64'(req_data),   64'(0));
    checkOutput("reset count",  64'(fifo_count), 64'(0));
    checkOutput("reset errors", 64'({short_err, long_err, ovf_err}), 64'(0));
    reset = 1'b0;
    step();

    // Legal write frame, held until drained.
    sendFrame("write", 64'h0000_1234_DEAD_BEEF, 6, 1'b1, 1'b0, 1'b0);
    checkHead("write head", 1'b1, 16'h1234, 32'hDEAD_BEEF);
    checkOutput("write count", 64'(fifo_count), 64'(1));
    step();
    checkHead("write hold", 1'b1, 16'h1234, 32'hDEAD_BEEF);
    drainOne("write drain", 3'd0);
    checkOutput("write drained valid", 64'(req_valid), 64'(0));

    // Read frame ended with ready high: no pop while empty, pop on the next edge.
    sendFrame("read", 64'h0000_ABCD_0000_0000, 6, 1'b0, 1'b1, 1'b0);
    checkHead("read head", 1'b0, 16'hABCD, 32'h0000_0000);
    step();
    req_ready = 1'b0;
    checkOutput("read popped count", 64'(fifo_count), 64'(0));

    // Short frame is discarded, the next legal one is accepted.
    sendFrame("short", 64'h0000_0000_1111_2222, 4, 1'b1, 1'b0, 1'b0);
    checkOutput("short count", 64'(fifo_count), 64'(0));
    step();
    checkOutput("short pulse gone", 64'(short_err), 64'(0));
    sendFrame("after short", 64'h0000_5555_CAFE_F00D, 6, 1'b1, 1'b0, 1'b0);
    checkHead("after short head", 1'b1, 16'h5555, 32'hCAFE_F00D);
    drainOne("after short drain", 3'd0);

    // Long frame keeps only the first six beats.
    sendFrame("long", 64'h9988_7766_1122_3344, 8, 1'b0, 1'b0, 1'b0);
    checkHead("long head", 1'b0, 16'h7766, 32'h1122_3344);
    drainOne("long drain", 3'd0);

    // Fill the queue; the fifth frame overflows.
    for (int k = 0; k < 5; k++) begin
      sendFrame($sformatf("fill%0d", k), {16'h0, 16'h1000 + 16'(k), 32'hA000_0000 + 32'(k)},
                6, 1'(k & 1), 1'b0, 1'(k == 4));
      checkOutput($sformatf("fill%0d count", k), 64'(fifo_count), 64'((k < 4) ? k + 1 : 4));
    end
    checkHead("full head", 1'b0, 16'h1000, 32'hA000_0000);

    // Push into a full queue with a simultaneous pop is accepted.
    sendFrame("full swap", {16'h0, 16'h1005, 32'hA000_0005}, 6, 1'b1, 1'b1, 1'b0);
    req_ready = 1'b0;
    checkOutput("full swap count", 64'(fifo_count), 64'(4));
    for (int j = 0; j < 4; j++) begin
      int k;
      k = (j == 3) ? 5 : j + 1;
      checkHead($sformatf("drain%0d", j), 1'(k & 1), 16'h1000 + 16'(k), 32'hA000_0000 + 32'(k));
      drainOne($sformatf("drain%0d", j), 3'(3 - j));
    end
    checkOutput("drained valid", 64'(req_valid), 64'(0));

    // Reset in the middle of a frame discards it silently.
    applyStimulus(1'b1, 8'h11);
    applyStimulus(1'b1, 8'h22);
    applyStimulus(1'b1, 8'h33);
    reset = 1'b1;
    applyStimulus(1'b0, 8'h00);
    checkOutput("midreset errors", 64'({short_err, long_err, ovf_err}), 64'(0));
    checkOutput("midreset count",  64'(fifo_count), 64'(0));
    reset = 1'b0;
    step();
    checkOutput("postreset errors", 64'({short_err, long_err, ovf_err}), 64'(0));
    checkOutput("postreset count",  64'(fifo_count), 64'(0));
    sendFrame("fresh", 64'h0000_0F0F_1357_9BDF, 6, 1'b0, 1'b0, 1'b0);
    checkHead("fresh head", 1'b0, 16'h0F0F, 32'h1357_9BDF);
    drainOne("fresh drain", 3'd0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
